// File: rtl/mwadd_pkg.sv
// Shared types and defaults for the chunked multi-word adder controller.
package mwadd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_N = 32;
    localparam int DEF_K = 4;

    // Chunk index needs at least one bit even when there is a single chunk.
    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/multiword_adder_ctrl_rca.sv
// N-bit ripple-carry adder used for one chunk of the multi-word add.
import mwadd_pkg::*;

module rippleCarryAdder #(
    parameter int N = DEF_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/multiword_adder_ctrl.sv
// Sequential W=N*K bit adder: one N-bit chunk per cycle through a single ripple adder.
// Optional subtract mode (in_sub port) is built when MWADD_SUB_EN is defined.
//
// state | meaning
// IDLE  | waiting for an operand set, in_ready high
// RUN   | adding chunk idx, carry kept in carry_q
// DONE  | result held on out_sum/out_cout until out_ready
import mwadd_pkg::*;

module multiword_adder_ctrl #(
    parameter int N = DEF_N,
    parameter int K = DEF_K
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*K-1:0] in_a,
    input  logic [N*K-1:0] in_b,
    input  logic           in_cin,
`ifdef MWADD_SUB_EN
    input  logic           in_sub,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*K-1:0] out_sum,
    output logic           out_cout,
    output logic           busy
);

    localparam int W  = N * K;
    localparam int IW = idx_width(K);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic [W-1:0]    a_q, b_q, sum_q;
    logic [N-1:0]    chunk_a, chunk_b, chunk_sum;
    logic            chunk_cout;
    logic            last;

    assign last    = (idx_q == IW'(K - 1));
    assign chunk_a = a_q[idx_q * N +: N];
    assign chunk_b = b_q[idx_q * N +: N];

    rippleCarryAdder #(.N(N)) u_rca (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so B is inverted once at capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        idx_q <= '0;
`ifdef MWADD_SUB_EN
                        b_q     <= in_sub ? ~in_b : in_b;
                        carry_q <= in_sub | in_cin;
`else
                        b_q     <= in_b;
                        carry_q <= in_cin;
`endif
                    end
                end
                RUN: begin
                    sum_q[idx_q * N +: N] <= chunk_sum;
                    carry_q               <= chunk_cout;
                    if (!last) idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = carry_q;

endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Scoreboard bench for multiword_adder_ctrl (N=8, K=4) plus a K=1 instance.
module tb_multiword_adder_ctrl;

    localparam int N = 8;
    localparam int K = 4;
    localparam int W = N * K;
`ifdef MWADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_cin;
    logic [W-1:0] in_a, in_b, out_sum;
    logic         out_valid, out_ready, out_cout, busy;
`ifdef MWADD_SUB_EN
    logic         in_sub;
`endif

    logic         k1_in_valid, k1_in_ready, k1_in_cin;
    logic [N-1:0] k1_in_a, k1_in_b, k1_out_sum;
    logic         k1_out_valid, k1_out_ready, k1_out_cout, k1_busy;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_mode = 1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multiword_adder_ctrl #(.N(N), .K(K)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef MWADD_SUB_EN
        .in_sub(in_sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    multiword_adder_ctrl #(.N(N), .K(1)) dut_k1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(k1_in_valid), .in_ready(k1_in_ready),
        .in_a(k1_in_a), .in_b(k1_in_b), .in_cin(k1_in_cin),
`ifdef MWADD_SUB_EN
        .in_sub(1'b0),
`endif
        .out_valid(k1_out_valid), .out_ready(k1_out_ready),
        .out_sum(k1_out_sum), .out_cout(k1_out_cout), .busy(k1_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic, no chunking.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t       r;
        logic [W:0] s;
        if (sub && SUB_EN) begin
            r.sum  = a - b;
            r.cout = (a >= b);
        end else begin
            s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            r.sum  = s[W-1:0];
            r.cout = s[W];
        end
        r.acc = 0;
        return r;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
            return;
        end
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
`ifdef MWADD_SUB_EN
        in_sub = sub;
`endif
        e = model(a, b, cin, sub);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom_range(0, 1));
`ifdef MWADD_SUB_EN
        in_sub = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    initial begin : ready_driver
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        end
    end

    initial begin : monitor
        bit seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("out_valid_unexpected", {63'd0, out_valid}, 64'd0);
                end else begin
                    if (!seen) begin
                        chk("latency", 64'(cyc), 64'(sb[0].acc + K));
                        seen = 1'b1;
                    end
                    chk("out_sum", 64'(out_sum), 64'(sb[0].sum));
                    chk("out_cout", {63'd0, out_cout}, {63'd0, sb[0].cout});
                    chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
                    chk("busy_in_done", {63'd0, busy}, 64'd1);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        exp_t         e2;
        int           n;
        logic [N-1:0] ra, rb;
        logic [N:0]   rs;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
`ifdef MWADD_SUB_EN
        in_sub = 1'b0;
`endif
        k1_in_valid = 1'b0; k1_in_a = '0; k1_in_b = '0; k1_in_cin = 1'b0; k1_out_ready = 1'b0;

        #12;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_cout", {63'd0, out_cout}, 64'd0);
        chk("rst_k1_in_ready", {63'd0, k1_in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Carry ripple across chunks and full wrap.
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send(32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        drain();

        ready_mode = 2;
        for (int i = 0; i < 40; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        drain();

        // Consumer stalls in DONE while a second operand set is already offered.
        ready_mode = 0;
        send(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'hCAFE_0001; in_b = 32'h3501_FFFF; in_cin = 1'b0;
`ifdef MWADD_SUB_EN
        in_sub = 1'b0;
`endif
        e2 = model(32'hCAFE_0001, 32'h3501_FFFF, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reach_done", {63'd0, out_valid}, 64'd1);
        repeat (10) begin
            @(negedge clk);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
        ready_mode = 1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_release_idle", {63'd0, in_ready}, 64'd1);
        e2.acc = cyc + 1;
        sb.push_back(e2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Reset during the second RUN cycle aborts the operation.
        send(32'hA5A5_5A5A, 32'h1111_2222, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_out_sum", 64'(out_sum), 64'd0);
        chk("abort_out_cout", {63'd0, out_cout}, 64'd0);
        void'(sb.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0);
        drain();

        // Subtract mode: in_cin is ignored when subtracting.
        if (SUB_EN) begin
            send(32'd5, 32'd7, 1'b0, 1'b1);
            send(32'd7, 32'd5, 1'b0, 1'b1);
            send(32'd9, 32'd9, 1'b0, 1'b1);
            ready_mode = 2;
            for (int i = 0; i < 12; i++)
                send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            ready_mode = 1;
            drain();
        end

        // Single-chunk build: one RUN cycle.
        @(negedge clk);
        k1_in_valid = 1'b1; k1_in_a = 8'h80; k1_in_b = 8'h80; k1_in_cin = 1'b0; k1_out_ready = 1'b0;
        @(posedge clk); #1;
        k1_in_valid = 1'b0;
        @(negedge clk);
        chk("k1_run_no_valid", {63'd0, k1_out_valid}, 64'd0);
        @(negedge clk);
        chk("k1_out_valid", {63'd0, k1_out_valid}, 64'd1);
        chk("k1_out_sum", 64'(k1_out_sum), 64'h00);
        chk("k1_out_cout", {63'd0, k1_out_cout}, 64'd1);
        k1_out_ready = 1'b1;
        @(negedge clk);
        chk("k1_back_idle", {63'd0, k1_in_ready}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rs = {1'b0, ra} + {1'b0, rb} + 9'd1;
            k1_in_valid = 1'b1; k1_in_a = ra; k1_in_b = rb; k1_in_cin = 1'b1;
            @(posedge clk); #1;
            k1_in_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("k1_rand_valid", {63'd0, k1_out_valid}, 64'd1);
            chk("k1_rand_sum", 64'(k1_out_sum), 64'(rs[N-1:0]));
            chk("k1_rand_cout", {63'd0, k1_out_cout}, {63'd0, rs[N]});
            @(negedge clk);
        end

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
